// File: rtl/rx_frame_scheduler_pkg.sv
// Shared types and helpers for the receive frame scheduler: state encoding,
// frame-length/timer-width arithmetic and the 6-bit offset saturator.
package rx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SEARCH  = 2'b01,
        ST_CONFIRM = 2'b10,
        ST_TRACK   = 2'b11
    } state_t;

    function automatic int frame_len(input int fft_size, input int cp_size,
                                     input int n_symb, input int gap);
        return n_symb * (fft_size + cp_size) + gap;
    endfunction

    function automatic int timer_width(input int len);
        return (len > 2) ? $clog2(len) : 1;
    endfunction

    // Clamp an 8-bit signed sum into the signed 6-bit offset range
    function automatic logic signed [5:0] sat6(input logic signed [7:0] v);
        logic signed [5:0] r;
        if (v > 8'sh1F) begin
            r = 6'sh1F;
        end else if (v < 8'shE0) begin
            r = 6'sh20;
        end else begin
            r = v[5:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_frame_timer.sv
// Flywheel frame timer: wrap counter advancing on sample strobes, plus the
// armed flag and acceptance-window decoding around the expected frame start.
module rx_frame_timer
    import rx_sched_pkg::*;
#(
    parameter int FRAME_LEN = 52800,
    parameter int WIN       = 8,
    parameter int TW        = timer_width(FRAME_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_val,
    input  logic          hit,
    input  logic          arm_en,
    output logic [TW-1:0] timer,
    output logic          armed,
    output logic          win_close,
    output logic          in_win
);

    localparam logic [TW-1:0] LAST_T   = TW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] ARM_T    = TW'(FRAME_LEN - WIN);
    localparam logic [TW-1:0] CLOSE_T  = TW'(WIN);
    localparam logic [TW-1:0] RELOAD_T = TW'(1);
    localparam logic [TW-1:0] ONE_T    = TW'(1);

    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_inc_s;
    logic          armed_r;
    logic          win_close_s;
    logic          in_win_s;

    // Next timer value and window decodes
    always_comb begin
        timer_inc_s = {TW{1'b0}};
        if (timer_r == LAST_T) begin
            timer_inc_s = {TW{1'b0}};
        end else begin
            timer_inc_s = timer_r + ONE_T;
        end
        win_close_s = armed_r & in_val & (timer_r == CLOSE_T);
        in_win_s    = (timer_r >= ARM_T) | (timer_r <= CLOSE_T);
    end

    // Counter and armed flag; a hit marks the current sample as frame sample 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= {TW{1'b0}};
            armed_r <= 1'b0;
        end else if (clr) begin
            timer_r <= {TW{1'b0}};
            armed_r <= 1'b0;
        end else if (in_val) begin
            if (hit) begin
                timer_r <= RELOAD_T;
                armed_r <= 1'b0;
            end else begin
                timer_r <= timer_inc_s;
                if (win_close_s) begin
                    armed_r <= 1'b0;
                end else if (arm_en && (timer_inc_s == ARM_T)) begin
                    armed_r <= 1'b1;
                end
            end
        end
    end

    assign timer     = timer_r;
    assign armed     = armed_r;
    assign win_close = win_close_s;
    assign in_win    = in_win_s;

endmodule

// File: rtl/rx_frame_scheduler.sv
// Frame-timing controller driving the CP remover's start-of-frame pulse.
// Define RX_SCHED_FLYWHEEL_EN to emit a flywheel osop on every missed peak.
module rx_frame_scheduler
    import rx_sched_pkg::*;
#(
    parameter int FFTSIZE   = 1024,
    parameter int CPSIZE    = 32,
    parameter int N_SYMB    = 50,
    parameter int GAP       = 0,
    parameter int WIN       = 8,
    parameter int LOCK_HITS = 2,
    parameter int MISS_MAX  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_val,
    input  logic              peak_val,
    input  logic signed [5:0] peak_off,
    output logic              osop,
    output logic signed [5:0] delay_sop,
    output logic              lock,
    output logic [1:0]        state,
    output logic signed [7:0] terr,
    output logic [7:0]        miss_cnt,
    output logic [15:0]       frame_cnt
);

    localparam int              FRAME_LEN    = frame_len(FFTSIZE, CPSIZE, N_SYMB, GAP);
    localparam int              TW           = timer_width(FRAME_LEN);
    localparam logic [TW-1:0]   WIN_T        = TW'(WIN);
    localparam logic [7:0]      FRAME_LEN_LO = 8'(FRAME_LEN % 256);
    localparam logic [7:0]      LOCK_W       = 8'(LOCK_HITS);
    localparam logic [7:0]      MISS_W       = 8'(MISS_MAX);

    state_t            state_r;
    logic [7:0]        hits_r;
    logic [7:0]        misses_r;
    logic              osop_r;
    logic signed [5:0] delay_sop_r;
    logic              lock_r;
    logic signed [7:0] terr_r;
    logic [7:0]        miss_cnt_r;
    logic [15:0]       frame_cnt_r;

    logic [TW-1:0]     timer_s;
    logic              armed_s;
    logic              win_close_s;
    logic              in_win_s;
    logic              searching_s;
    logic              tracking_s;
    logic              hit_s;
    logic              miss_s;
    logic              enter_search_s;
    logic              clr_s;
    logic [7:0]        hits_inc_s;
    logic [7:0]        misses_inc_s;
    logic [7:0]        terr_s;

`ifdef RX_SCHED_FLYWHEEL_EN
    logic signed [5:0] last_off_r;
    logic signed [5:0] fly_dly_s;
`endif

    rx_frame_timer #(
        .FRAME_LEN (FRAME_LEN),
        .WIN       (WIN),
        .TW        (TW)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_s),
        .in_val    (in_val),
        .hit       (hit_s),
        .arm_en    (tracking_s),
        .timer     (timer_s),
        .armed     (armed_s),
        .win_close (win_close_s),
        .in_win    (in_win_s)
    );

    // Hit/miss qualification, counter increments and timing-error decode
    always_comb begin
        searching_s  = (state_r == ST_SEARCH);
        tracking_s   = (state_r == ST_CONFIRM) | (state_r == ST_TRACK);
        hit_s        = in_val & peak_val & (searching_s | (tracking_s & armed_s & in_win_s));
        miss_s       = win_close_s & tracking_s & ~hit_s;
        hits_inc_s   = (hits_r == 8'hFF) ? hits_r : hits_r + 8'd1;
        misses_inc_s = (misses_r == 8'hFF) ? misses_r : misses_r + 8'd1;

        enter_search_s = (state_r == ST_IDLE)
                       | ((state_r == ST_CONFIRM) & miss_s)
                       | ((state_r == ST_TRACK) & miss_s & (misses_inc_s == MISS_W));
        clr_s = ~en | enter_search_s;

        // Early peaks report timer-FRAME_LEN; only the low byte is kept
        terr_s = 8'h00;
        if (searching_s) begin
            terr_s = 8'h00;
        end else if (timer_s <= WIN_T) begin
            terr_s = 8'(timer_s);
        end else begin
            terr_s = 8'(timer_s) - FRAME_LEN_LO;
        end
    end

`ifdef RX_SCHED_FLYWHEEL_EN
    // Flywheel offset predicts the late edge of the acceptance window
    always_comb begin
        fly_dly_s = sat6(8'({{2{last_off_r[5]}}, last_off_r}) + 8'(WIN));
    end
`endif

    // Acquisition/lock FSM with registered outputs and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            hits_r      <= 8'd0;
            misses_r    <= 8'd0;
            osop_r      <= 1'b0;
            delay_sop_r <= 6'sd0;
            lock_r      <= 1'b0;
            terr_r      <= 8'sd0;
            miss_cnt_r  <= 8'd0;
            frame_cnt_r <= 16'd0;
`ifdef RX_SCHED_FLYWHEEL_EN
            last_off_r  <= 6'sd0;
`endif
        end else if (!en) begin
            state_r     <= ST_IDLE;
            hits_r      <= 8'd0;
            misses_r    <= 8'd0;
            osop_r      <= 1'b0;
            delay_sop_r <= 6'sd0;
            lock_r      <= 1'b0;
            terr_r      <= 8'sd0;
            frame_cnt_r <= 16'd0;
`ifdef RX_SCHED_FLYWHEEL_EN
            last_off_r  <= 6'sd0;
`endif
        end else begin
            osop_r <= 1'b0;
            if (hit_s) begin
                osop_r      <= 1'b1;
                delay_sop_r <= peak_off;
                terr_r      <= terr_s;
                frame_cnt_r <= frame_cnt_r + 16'd1;
                hits_r      <= hits_inc_s;
                misses_r    <= 8'd0;
`ifdef RX_SCHED_FLYWHEEL_EN
                last_off_r  <= peak_off;
`endif
            end else if (miss_s) begin
                hits_r      <= 8'd0;
                misses_r    <= misses_inc_s;
                miss_cnt_r  <= (miss_cnt_r == 8'hFF) ? miss_cnt_r : miss_cnt_r + 8'd1;
`ifdef RX_SCHED_FLYWHEEL_EN
                osop_r      <= 1'b1;
                delay_sop_r <= fly_dly_s;
                frame_cnt_r <= frame_cnt_r + 16'd1;
`endif
            end

            case (state_r)
                ST_IDLE: begin
                    state_r  <= ST_SEARCH;
                    hits_r   <= 8'd0;
                    misses_r <= 8'd0;
                    lock_r   <= 1'b0;
                end
                ST_SEARCH: begin
                    if (hit_s) begin
                        state_r <= ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (hit_s && (hits_inc_s == LOCK_W)) begin
                        state_r <= ST_TRACK;
                        lock_r  <= 1'b1;
                    end else if (miss_s) begin
                        state_r  <= ST_SEARCH;
                        hits_r   <= 8'd0;
                        misses_r <= 8'd0;
                        lock_r   <= 1'b0;
                    end
                end
                ST_TRACK: begin
                    if (miss_s && (misses_inc_s == MISS_W)) begin
                        state_r  <= ST_SEARCH;
                        hits_r   <= 8'd0;
                        misses_r <= 8'd0;
                        lock_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign osop      = osop_r;
    assign delay_sop = delay_sop_r;
    assign lock      = lock_r;
    assign state     = state_r;
    assign terr      = terr_r;
    assign miss_cnt  = miss_cnt_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_rx_frame_scheduler.sv
// Directed scoreboard bench for rx_frame_scheduler on a short 160-sample frame;
// expectations adapt to whether RX_SCHED_FLYWHEEL_EN is defined.
module tb_rx_frame_scheduler;

    localparam int L = 160;
    localparam int W = 8;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              in_val;
    logic              peak_val;
    logic signed [5:0] peak_off;
    logic              osop;
    logic signed [5:0] delay_sop;
    logic              lock;
    logic [1:0]        state;
    logic signed [7:0] terr;
    logic [7:0]        miss_cnt;
    logic [15:0]       frame_cnt;

    typedef struct {
        int         due;
        logic [5:0] dly;
        logic [7:0] terr;
        logic [15:0] fc;
        logic       lock;
    } exp_t;

    exp_t sb[$];

    int cyc;
    int passes;
    int fails;
    int total;
    int exp_frames;
    int exp_miss;
    logic [5:0] exp_dly;
    logic [7:0] exp_terr;
    logic signed [5:0] last_hit_off;

    rx_frame_scheduler #(
        .FFTSIZE   (64),
        .CPSIZE    (16),
        .N_SYMB    (2),
        .GAP       (0),
        .WIN       (W),
        .LOCK_HITS (2),
        .MISS_MAX  (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_val    (in_val),
        .peak_val  (peak_val),
        .peak_off  (peak_off),
        .osop      (osop),
        .delay_sop (delay_sop),
        .lock      (lock),
        .state     (state),
        .terr      (terr),
        .miss_cnt  (miss_cnt),
        .frame_cnt (frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total = total + 1;
        assert (obs === expv) passes = passes + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h required %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic check_osop();
        exp_t e;
        if (osop === 1'b1 || (sb.size() > 0 && sb[0].due <= cyc)) begin
            if (sb.size() == 0) begin
                check("osop_unexpected", 64'(osop), 64'd0);
            end else begin
                e = sb.pop_front();
                check("osop_cycle", 64'(cyc), 64'(e.due));
                check("osop_fields", {osop, delay_sop, terr, frame_cnt, lock},
                      {1'b1, e.dly, e.terr, e.fc, e.lock});
            end
        end
    endtask

    task automatic tick(input logic v, input logic pv, input logic [5:0] off);
        in_val   = v;
        peak_val = pv;
        peak_off = off;
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        check_osop();
    endtask

    // n counted samples; a non-strobed cycle carrying a stray peak is slipped in now and then
    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) begin
            if (i % 29 == 28) tick(1'b0, 1'b1, 6'd9);
            tick(1'b1, 1'b0, 6'd0);
        end
    endtask

    task automatic hit(input logic [5:0] off, input logic [7:0] t_exp, input logic lk);
        exp_t e;
        exp_frames = exp_frames + 1;
        e.due  = cyc + 1;
        e.dly  = off;
        e.terr = t_exp;
        e.fc   = 16'(exp_frames);
        e.lock = lk;
        sb.push_back(e);
        exp_dly      = off;
        exp_terr     = t_exp;
        last_hit_off = off;
        tick(1'b1, 1'b1, off);
    endtask

    task automatic close_miss(input logic lk);
        int v;
        exp_t e;
        v = int'(last_hit_off) + W;
        if (v > 31) v = 31;
        if (v < -32) v = -32;
`ifdef RX_SCHED_FLYWHEEL_EN
        exp_frames = exp_frames + 1;
        e.due  = cyc + 1;
        e.dly  = 6'(v);
        e.terr = exp_terr;
        e.fc   = 16'(exp_frames);
        e.lock = lk;
        sb.push_back(e);
        exp_dly = 6'(v);
`else
        e.due = v;
        e.lock = lk;
`endif
        exp_miss = exp_miss + 1;
        tick(1'b1, 1'b0, 6'd0);
        check("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
        check("miss_delay_sop", 64'(6'(delay_sop)), 64'(exp_dly));
    endtask

    initial begin
        cyc = 0; passes = 0; fails = 0; total = 0;
        exp_frames = 0; exp_miss = 0;
        exp_dly = 6'd0; exp_terr = 8'd0; last_hit_off = 6'sd0;
        rst_n = 1'b0; en = 1'b0; in_val = 1'b0; peak_val = 1'b0; peak_off = 6'sd0;

        // reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {osop, delay_sop, lock, state, terr, miss_cnt, frame_cnt}, 64'd0);
        rst_n = 1'b1;
        tick(1'b1, 1'b1, 6'd5);
        check("idle_outputs", {osop, delay_sop, lock, state, terr, miss_cnt, frame_cnt}, 64'd0);

        // search with no peaks for two frame lengths
        en = 1'b1;
        idle_n(2 * L);
        check("search_state", 64'(state), 64'd1);
        check("search_quiet", {osop, delay_sop, lock, terr, miss_cnt, frame_cnt}, 64'd0);

        // acquisition
        hit(6'd3, 8'd0, 1'b0);
        check("confirm_state", 64'(state), 64'd2);
        idle_n(L - 1);
        hit(6'd3, 8'd0, 1'b1);
        idle_n(L - 1);
        hit(6'd3, 8'd0, 1'b1);
        check("track_state", {state, lock}, {2'b11, 1'b1});

        // drift: five late, then four early relative to the realigned timer
        idle_n(L - 1 + 5);
        hit(6'd3, 8'd5, 1'b1);
        idle_n(L - 1 - 4);
        hit(6'd3, 8'hFC, 1'b1);
        check("drift_lock", {state, lock}, {2'b11, 1'b1});

        // single dropped peak
        idle_n(L - 1 + W);
        close_miss(1'b1);
        check("one_miss_lock", {state, lock}, {2'b11, 1'b1});
        idle_n(L - W - 1);
        hit(6'd3, 8'd0, 1'b1);

        // window edges: mid-frame peak ignored, peak on the closing sample accepted
        idle_n(79);
        tick(1'b1, 1'b1, 6'd5);
        idle_n(L - 81 + W);
        hit(6'd28, 8'd8, 1'b1);
        check("edge_no_miss", 64'(miss_cnt), 64'(exp_miss));

        // saturated flywheel offset
        idle_n(L - 1 + W);
        close_miss(1'b1);
        idle_n(L - W - 1);
        hit(6'd3, 8'd0, 1'b1);

        // three consecutive drops lose lock
        idle_n(L - 1 + W);
        close_miss(1'b1);
        idle_n(L - 1);
        close_miss(1'b1);
        idle_n(L - 1);
        close_miss(1'b0);
        check("lock_lost", {state, lock}, {2'b01, 1'b0});

        // reacquire, then abort mid-frame
        idle_n(5);
        hit(6'd7, 8'd0, 1'b0);
        idle_n(40);
        en = 1'b0;
        tick(1'b1, 1'b0, 6'd0);
        check("abort_outputs", {osop, delay_sop, lock, state, terr, frame_cnt}, 64'd0);
        check("abort_miss_cnt", 64'(miss_cnt), 64'd5);
        repeat (3) tick(1'b1, 1'b1, 6'd4);
        check("idle_hold", {osop, delay_sop, lock, state, terr, frame_cnt}, 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
